// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for the shared ALU: latches an opcode and operands on start,
// holds the one-hot ALU control for an op-dependent number of cycles, then captures ZHI/ZLO.
module alu_sequencer #(
    parameter int BITS       = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [BITS-1:0]   a_in,
    input  logic [BITS-1:0]   b_in,
    input  logic [2*BITS-1:0] alu_result,
    output logic [11:0]       ctrl_signal,
    output logic [BITS-1:0]   X,
    output logic [BITS-1:0]   Y,
    output logic [BITS-1:0]   zhi,
    output logic [BITS-1:0]   zlo,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE_N = CNT_W'(1);

    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] exec_len;
    logic             accept;
    logic             reject;
    logic             finish;

    assign accept = (state_q == IDLE) && start;
    assign reject = (opcode >= 4'd12) || ((opcode == OP_DIV) && (b_in == '0));
    assign finish = (state_q == EXEC) && (cnt_q == ONE_N);

    always_comb begin
        exec_len = ONE_N;
        case (opcode)
            OP_MUL:  exec_len = MUL_N;
            OP_DIV:  exec_len = DIV_N;
            default: exec_len = ONE_N;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = reject ? DONE : EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == ONE_N) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ctrl_signal is decoded from the latched op only while executing,
    // so it is all-zero outside EXEC and can never be multi-hot.
    always_comb begin
        ctrl_signal = '0;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        if (state_q == EXEC) begin
            for (int unsigned i = 0; i < 12; i++) begin
                if (op_q == 4'(i)) begin
                    ctrl_signal[i] = 1'b1;
                end
            end
        end
    end

    // Operand, result and counter registers
    always_ff @(posedge clock) begin
        if (clear) begin
            X     <= '0;
            Y     <= '0;
            zhi   <= '0;
            zlo   <= '0;
            err   <= 1'b0;
            op_q  <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            X     <= a_in;
            Y     <= b_in;
            op_q  <= opcode;
            err   <= reject;
            cnt_q <= exec_len;
        end else if (state_q == EXEC) begin
            cnt_q <= cnt_q - ONE_N;
            if (finish) begin
                zhi <= alu_result[2*BITS-1:BITS];
                zlo <= alu_result[BITS-1:0];
                err <= 1'b0;
            end
        end
    end

endmodule
